// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C transmit byte feeder: FSM states, ACK/NACK levels
// and bit-counter sizing.
package i2c_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_SHIFT    = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Bit counter counts DATASIZE-1 down to 0; never narrower than one bit.
    function automatic int bitcnt_width(input int datasize);
        return (datasize > 2) ? $clog2(datasize) : 1;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Byte serialiser: parallel load, shift-left-on-accept with 1-fill, MSB output
// and a down-counting bit counter flagging the last bit.
module tx_shift_reg
    import i2c_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [DATASIZE-1:0] data_i,
    input  logic                shift_i,
    output logic                msb_o,
    output logic                last_o
);

    localparam int BW = bitcnt_width(DATASIZE);

    logic [DATASIZE-1:0] sreg_q, sreg_d;
    logic [BW-1:0]       cnt_q,  cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = data_i;
            cnt_d  = BW'(DATASIZE - 1);
        end else if (shift_i) begin
            sreg_d = {sreg_q[DATASIZE-2:0], 1'b1};
            cnt_d  = cnt_q - BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '1;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign msb_o  = sreg_q[DATASIZE-1];
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_tx_byte_feeder.sv
// Pops bytes from the async FIFO read port and feeds them MSB-first to the I2C
// bit engine, then waits for ACK/NACK. Define I2C_TX_LEN_LIMIT_EN for len_i.
module i2c_tx_byte_feeder
    import i2c_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int CNTW     = 8
) (
    input  logic                rclk_i,
    input  logic                rst_i,
    input  logic [DATASIZE-1:0] rdata_i,
    input  logic                rempty_i,
    output logic                rinc_o,
    input  logic                start_i,
`ifdef I2C_TX_LEN_LIMIT_EN
    input  logic [CNTW-1:0]     len_i,
`endif
    input  logic                stop_i,
    output logic                bit_valid_o,
    output logic                bit_o,
    input  logic                bit_ready_i,
    input  logic                ack_valid_i,
    input  logic                ack_i,
    output logic                byte_done_o,
    output logic                nack_o,
    output logic                busy_o,
    output logic [CNTW-1:0]     byte_cnt_o
);

    logic [1:0]      state_q, state_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            msb, last_bit;
`ifdef I2C_TX_LEN_LIMIT_EN
    logic [CNTW-1:0] len_q, len_d;
`endif

    assign rinc_o      = (state_q == ST_FETCH) & ~rempty_i & ~stop_i;
    assign bit_valid_o = (state_q == ST_SHIFT);
    assign bit_o       = (state_q == ST_SHIFT) ? msb : 1'b1;

    always_comb begin
        state_d = state_q;
        nack_d  = nack_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef I2C_TX_LEN_LIMIT_EN
        len_d   = len_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    nack_d  = 1'b0;
                    cnt_d   = '0;
`ifdef I2C_TX_LEN_LIMIT_EN
                    len_d   = len_i;
`endif
                end
            end
            ST_FETCH: begin
                if (stop_i)         state_d = ST_IDLE;
                else if (!rempty_i) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_ready_i && last_bit) state_d = ST_WAIT_ACK;
            end
            default: begin
                if (ack_valid_i) begin
                    if (ack_i == ACK) begin
                        done_d  = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
                        state_d = ST_FETCH;
`ifdef I2C_TX_LEN_LIMIT_EN
                        // Zero length means the session is unlimited.
                        if (len_q != '0 && cnt_d == len_q) state_d = ST_IDLE;
`endif
                    end else begin
                        nack_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge rclk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef I2C_TX_LEN_LIMIT_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef I2C_TX_LEN_LIMIT_EN
            len_q   <= len_d;
`endif
        end
    end

    tx_shift_reg #(
        .DATASIZE (DATASIZE)
    ) u_shift (
        .clk_i   (rclk_i),
        .rst_i   (rst_i),
        .load_i  (rinc_o),
        .data_i  (rdata_i),
        .shift_i (bit_valid_o & bit_ready_i),
        .msb_o   (msb),
        .last_o  (last_bit)
    );

    assign byte_done_o = done_q;
    assign nack_o      = nack_q;
    assign busy_o      = busy_q;
    assign byte_cnt_o  = cnt_q;

endmodule

// File: tb/tb_i2c_tx_byte_feeder.sv
// Directed bench for i2c_tx_byte_feeder with a simple FIFO model and bit engine.
module tb_i2c_tx_byte_feeder;

    localparam int CNTW_TB = 3;

    logic               rclk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [7:0]         rdata_i;
    logic               rempty_i;
    logic               rinc_o;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic               bit_valid_o;
    logic               bit_o;
    logic               bit_ready_i = 1'b0;
    logic               ack_valid_i = 1'b0;
    logic               ack_i = 1'b0;
    logic               byte_done_o;
    logic               nack_o;
    logic               busy_o;
    logic [CNTW_TB-1:0] byte_cnt_o;
`ifdef I2C_TX_LEN_LIMIT_EN
    logic [CNTW_TB-1:0] len_i = '0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int done_cnt = 0;

    assign rempty_i = (rd_ptr == wr_ptr);
    assign rdata_i  = fifo_mem[rd_ptr[5:0]];

    always #5 rclk_i = ~rclk_i;

    always @(posedge rclk_i) begin
        if (rinc_o) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (byte_done_o) done_cnt <= done_cnt + 1;
    end

    i2c_tx_byte_feeder #(
        .DATASIZE (8),
        .CNTW     (CNTW_TB)
    ) dut (
        .rclk_i      (rclk_i),
        .rst_i       (rst_i),
        .rdata_i     (rdata_i),
        .rempty_i    (rempty_i),
        .rinc_o      (rinc_o),
        .start_i     (start_i),
`ifdef I2C_TX_LEN_LIMIT_EN
        .len_i       (len_i),
`endif
        .stop_i      (stop_i),
        .bit_valid_o (bit_valid_o),
        .bit_o       (bit_o),
        .bit_ready_i (bit_ready_i),
        .ack_valid_i (ack_valid_i),
        .ack_i       (ack_i),
        .byte_done_o (byte_done_o),
        .nack_o      (nack_o),
        .busy_o      (busy_o),
        .byte_cnt_o  (byte_cnt_o)
    );

    task automatic tick();
        @(posedge rclk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    // Waits for the byte, shifts it out with ready always or randomly high,
    // then answers the ACK slot. Returns right after the ACK edge.
    task automatic xfer(input string tag, input logic [7:0] exp_byte,
                        input logic nack, input bit rand_ready);
        logic [7:0] got;
        int nbits;
        int stab_err;
        int budget;
        logic prev_pending;
        logic prev_bit;
        got = '0;
        nbits = 0;
        stab_err = 0;
        prev_pending = 1'b0;
        prev_bit = 1'b1;
        budget = 0;
        while (!bit_valid_o && budget < 20) begin
            tick();
            budget++;
        end
        check({tag, "_valid_timeout"}, 32'(bit_valid_o), 32'd1);
        budget = 0;
        while (bit_valid_o && budget < 200) begin
            if (prev_pending && bit_o !== prev_bit) stab_err++;
            bit_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bit_ready_i) begin
                got = {got[6:0], bit_o};
                nbits++;
            end
            prev_pending = !bit_ready_i;
            prev_bit = bit_o;
            tick();
            budget++;
        end
        bit_ready_i = 1'b0;
        check({tag, "_bits"}, 32'(got), 32'(exp_byte));
        check({tag, "_nbits"}, 32'(nbits), 32'd8);
        check({tag, "_stable"}, 32'(stab_err), 32'd0);
        check({tag, "_sda_release"}, 32'(bit_o), 32'd1);
        ack_valid_i = 1'b1;
        ack_i = nack;
        tick();
        ack_valid_i = 1'b0;
        ack_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int d0;
        int bad;

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_rinc", 32'(rinc_o), 32'd0);
        check("rst_bit_valid", 32'(bit_valid_o), 32'd0);
        check("rst_bit", 32'(bit_o), 32'd1);
        check("rst_done", 32'(byte_done_o), 32'd0);
        check("rst_nack", 32'(nack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(byte_cnt_o), 32'd0);

        // Single byte 0xA5, ACKed
        push(8'hA5);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("a5_rinc_n1", 32'(rinc_o), 32'd1);
        check("a5_busy", 32'(busy_o), 32'd1);
        tick();
        check("a5_valid_n2", 32'(bit_valid_o), 32'd1);
        check("a5_rinc_once", 32'(rinc_o), 32'd0);
        xfer("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_done", 32'(byte_done_o), 32'd1);
        check("a5_cnt", 32'(byte_cnt_o), 32'd1);
        check("a5_busy_fetch", 32'(busy_o), 32'd1);
        tick();
        check("a5_done_pulse", 32'(byte_done_o), 32'd0);
        check("a5_fetch_idle_line", 32'(bit_valid_o), 32'd0);
        check("a5_pops", 32'(pop_cnt), 32'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("a5_stop_busy", 32'(busy_o), 32'd0);

        // 0x3C ACK then 0xFF NACK
        p0 = pop_cnt;
        push(8'h3C);
        push(8'hFF);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        xfer("3c", 8'h3C, 1'b0, 1'b0);
        xfer("ff", 8'hFF, 1'b1, 1'b0);
        check("nack_flag", 32'(nack_o), 32'd1);
        check("nack_busy", 32'(busy_o), 32'd0);
        check("nack_cnt", 32'(byte_cnt_o), 32'd1);
        check("nack_no_done", 32'(byte_done_o), 32'd0);
        check("nack_pops", 32'(pop_cnt - p0), 32'd2);

        // New start clears NACK; FIFO empty so it waits in FETCH
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_nack_clr", 32'(nack_o), 32'd0);
        check("restart_cnt_clr", 32'(byte_cnt_o), 32'd0);
        check("restart_busy", 32'(busy_o), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rinc_o || bit_valid_o) bad++;
            tick();
        end
        check("empty_no_activity", 32'(bad), 32'd0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("empty_stop_busy", 32'(busy_o), 32'd0);

        // 0x81 with random backpressure
        push(8'h81);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        xfer("81", 8'h81, 1'b0, 1'b1);
        check("81_cnt", 32'(byte_cnt_o), 32'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;

        // Counter saturation at 2^CNTW-1 = 7
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) push(8'(i * 17 + 3));
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            xfer("sat", 8'(i * 17 + 3), 1'b0, 1'b0);
            if (i == 6) check("sat_cnt7", 32'(byte_cnt_o), 32'd7);
        end
        check("sat_cnt_hold", 32'(byte_cnt_o), 32'd7);
        tick();
        check("sat_done_pulses", 32'(done_cnt - d0), 32'd9);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;

        // Reset during the 4th bit of 0x55
        push(8'h55);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        bit_ready_i = 1'b1;
        tick();
        tick();
        tick();
        bit_ready_i = 1'b0;
        check("r55_bit4", 32'(bit_o), 32'd1);
        check("r55_valid", 32'(bit_valid_o), 32'd1);
        p0 = pop_cnt;
        rst_i = 1'b1;
        tick();
        check("r55_rinc", 32'(rinc_o), 32'd0);
        check("r55_bit_valid", 32'(bit_valid_o), 32'd0);
        check("r55_bit", 32'(bit_o), 32'd1);
        check("r55_done", 32'(byte_done_o), 32'd0);
        check("r55_nack", 32'(nack_o), 32'd0);
        check("r55_busy", 32'(busy_o), 32'd0);
        check("r55_cnt", 32'(byte_cnt_o), 32'd0);
        rst_i = 1'b0;
        push(8'h99);
        tick();
        tick();
        tick();
        check("r55_no_repop", 32'(pop_cnt - p0), 32'd0);
        check("r55_fifo_kept", 32'(rempty_i), 32'd0);

`ifdef I2C_TX_LEN_LIMIT_EN
        // Length limit of 2 with three bytes queued (0x99 already present)
        push(8'h11);
        push(8'h22);
        p0 = pop_cnt;
        d0 = done_cnt;
        len_i = 3'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        len_i = '0;
        xfer("len1", 8'h99, 1'b0, 1'b0);
        check("len1_cnt", 32'(byte_cnt_o), 32'd1);
        xfer("len2", 8'h11, 1'b0, 1'b0);
        check("len2_done", 32'(byte_done_o), 32'd1);
        check("len2_cnt", 32'(byte_cnt_o), 32'd2);
        check("len2_idle", 32'(busy_o), 32'd0);
        tick();
        tick();
        check("len_fifo_left", 32'(rempty_i), 32'd0);
        check("len_pops", 32'(pop_cnt - p0), 32'd2);
        check("len_done_pulses", 32'(done_cnt - d0), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
